// File: rtl/sfu_arbiter.sv
// sfu_arbiter: round-robin scheduler that grants the shared SFU to one requester per job,
// feeds its words, routes result beats back and aborts a stalled drain via a watchdog.
module sfu_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [6*NUM_REQ-1:0]    req_len,
  input  logic [4*NUM_REQ-1:0]    req_mode,
  input  logic [32*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]      req_grant,
  output logic                    req_feed,
  output logic [NUM_REQ-1:0]      rsp_valid,
  output logic [31:0]             rsp_data,
  output logic [NUM_REQ-1:0]      rsp_done,
  output logic [NUM_REQ-1:0]      rsp_err,
  output logic                    sfu_req,
  output logic [5:0]              sfu_cfg_len,
  output logic [3:0]              sfu_cfg_mode,
  output logic [31:0]             sfu_data_in,
  input  logic [31:0]             sfu_data_out,
  input  logic                    sfu_valid_out,
  output logic                    busy
);
  localparam int IW = $clog2(NUM_REQ);
  typedef enum logic [2:0] {IDLE, ISSUE, FEED, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d, rr_q, rr_d, pick;
  logic [IW:0] pick_c;
  logic [2*NUM_REQ-1:0] dbl;
  logic found, beat, err_q, err_d;
  logic [5:0] len_q, len_d, feed_q, feed_d;
  logic [3:0] mode_q, mode_d;
  logic [6:0] out_q, out_d, len_p1;
  logic [7:0] wd_q, wd_d;
  logic [NUM_REQ-1:0] own, rsp_valid_q;
  logic [31:0] rsp_data_q;
  // Rotating by rr_q turns "first set bit from rr_q upward" into a plain lowest-bit scan.
  assign dbl = {req_valid, req_valid} >> rr_q;
  always_comb begin
    pick_c = '0;
    found = |dbl;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (dbl[k]) pick_c = {1'b0, rr_q} + (IW+1)'(k);
    if (pick_c >= (IW+1)'(NUM_REQ)) pick_c = pick_c - (IW+1)'(NUM_REQ);
    pick = pick_c[IW-1:0];
  end
  assign own = {{(NUM_REQ-1){1'b0}}, 1'b1} << idx_q;
  assign len_p1 = {1'b0, len_q} + 7'd1;
  // Beats count in FEED too, but never beyond the expected len+1.
  assign beat = sfu_valid_out && (state_q == FEED || state_q == DRAIN) && out_q < len_p1;
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    len_d = len_q;
    mode_d = mode_q;
    rr_d = rr_q;
    feed_d = feed_q;
    out_d = out_q + {6'd0, beat};
    wd_d = wd_q;
    err_d = err_q;
    case (state_q)
      IDLE: if (found) begin
        idx_d = pick;
        len_d = req_len[pick*6 +: 6];
        mode_d = req_mode[pick*4 +: 4];
        state_d = ISSUE;
      end
      ISSUE: state_d = FEED;
      FEED: begin
        feed_d = feed_q + 6'd1;
        if (feed_q == len_q) begin
          feed_d = '0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        wd_d = beat ? 8'd0 : wd_q + 8'd1;
        if (out_d == len_p1) state_d = DONE;
        else if (!beat && wd_q == 8'(TIMEOUT - 1)) begin
          err_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        rr_d = (idx_q == IW'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
        feed_d = '0;
        out_d = '0;
        wd_d = '0;
        err_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q <= '0;
      rr_q <= '0;
      len_q <= '0;
      mode_q <= '0;
      feed_q <= '0;
      out_q <= '0;
      wd_q <= '0;
      err_q <= 1'b0;
      rsp_valid_q <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      rr_q <= rr_d;
      len_q <= len_d;
      mode_q <= mode_d;
      feed_q <= feed_d;
      out_q <= out_d;
      wd_q <= wd_d;
      err_q <= err_d;
      rsp_valid_q <= beat ? own : '0;
      if (beat) rsp_data_q <= sfu_data_out;
    end
  end
  assign busy = state_q != IDLE;
  assign req_grant = busy ? own : '0;
  assign req_feed = state_q == FEED;
  assign sfu_req = state_q == ISSUE;
  assign sfu_data_in = req_feed ? req_data[idx_q*32 +: 32] : '0;
  assign sfu_cfg_len = len_q;
  assign sfu_cfg_mode = mode_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data = rsp_data_q;
  assign rsp_done = (state_q == DONE && !err_q) ? own : '0;
  assign rsp_err = (state_q == DONE && err_q) ? own : '0;
endmodule

// File: tb/tb_sfu_arbiter.sv
// tb_sfu_arbiter: directed bench for sfu_arbiter with a cycle-scripted sfu result model.
module tb_sfu_arbiter;
  localparam int N = 4;
  logic clk = 1'b0;
  logic rst;
  logic [N-1:0] req_valid;
  logic [6*N-1:0] req_len;
  logic [4*N-1:0] req_mode;
  logic [32*N-1:0] req_data;
  logic [N-1:0] req_grant, rsp_valid, rsp_done, rsp_err;
  logic req_feed, sfu_req, sfu_valid_out, busy;
  logic [31:0] rsp_data, sfu_data_in, sfu_data_out;
  logic [5:0] sfu_cfg_len;
  logic [3:0] sfu_cfg_mode;
  int checks = 0, errors = 0;
  int wcnt [N];
  int issue_cyc, done_cyc, err_cyc, nfeed, nrsp, last_rsp;
  logic [N-1:0] iss_grant, done_vec, err_vec;
  logic [5:0] iss_len;
  logic [3:0] iss_mode;
  logic fed;

  sfu_arbiter #(.NUM_REQ(N), .TIMEOUT(255)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_len(req_len), .req_mode(req_mode),
    .req_data(req_data), .req_grant(req_grant), .req_feed(req_feed), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rsp_done(rsp_done), .rsp_err(rsp_err), .sfu_req(sfu_req),
    .sfu_cfg_len(sfu_cfg_len), .sfu_cfg_mode(sfu_cfg_mode), .sfu_data_in(sfu_data_in),
    .sfu_data_out(sfu_data_out), .sfu_valid_out(sfu_valid_out), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_grant"}, 32'(req_grant), 0);
    chk({tag, "_feed"}, 32'(req_feed), 0);
    chk({tag, "_sfu_req"}, 32'(sfu_req), 0);
    chk({tag, "_data_in"}, sfu_data_in, 0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
    chk({tag, "_rsp_data"}, rsp_data, 0);
    chk({tag, "_done"}, 32'(rsp_done), 0);
    chk({tag, "_err"}, 32'(rsp_err), 0);
    chk({tag, "_cfg_len"}, 32'(sfu_cfg_len), 0);
    chk({tag, "_cfg_mode"}, 32'(sfu_cfg_mode), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
  endtask

  // Runs one job owned by `who`; the sfu model drives nb beats in cycles bfrom..bfrom+nb-1.
  task automatic run(input int who, input int bfrom, input int nb, input int budget, input logic [N-1:0] drop);
    issue_cyc = 0; done_cyc = 0; err_cyc = 0; nfeed = 0; nrsp = 0; last_rsp = 0;
    done_vec = '0; err_vec = '0; fed = 1'b0;
    for (int c = 1; c <= budget; c++) begin
      @(posedge clk);
      #1;
      if (fed) begin
        wcnt[who]++;
        req_data[who*32 +: 32] = {8'(who), 24'(wcnt[who])};
      end
      #1;
      fed = req_feed;
      if (sfu_req) begin
        issue_cyc = c; iss_grant = req_grant; iss_len = sfu_cfg_len; iss_mode = sfu_cfg_mode;
      end
      if (req_feed) begin
        nfeed++;
        chk("feed_data", sfu_data_in, {8'(who), 24'(wcnt[who])});
      end
      if (|rsp_valid) begin
        chk("rsp_owner", 32'(rsp_valid), 32'(1 << who));
        chk("rsp_data", rsp_data, 32'hD000_0000 + 32'(nrsp));
        nrsp++;
        last_rsp = c;
      end
      if (|rsp_done) begin done_cyc = c; done_vec = rsp_done; end
      if (|rsp_err) begin err_cyc = c; err_vec = rsp_err; end
      sfu_valid_out = (c >= bfrom && c < bfrom + nb);
      sfu_data_out = 32'hD000_0000 + 32'(c - bfrom);
      if (done_cyc != 0 || err_cyc != 0) begin
        req_valid &= ~drop;
        sfu_valid_out = 1'b0;
        break;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0; req_len = '0; req_mode = '0; req_data = '0;
    sfu_valid_out = 1'b0; sfu_data_out = '0;
    for (int r = 0; r < N; r++) begin
      wcnt[r] = 0;
      req_data[r*32 +: 32] = {8'(r), 24'd0};
    end
    tick();
    tick();
    chk_idle_zero("reset");
    rst = 1'b0;
    tick();

    // Round-robin with everyone requesting continuously, len=0.
    req_valid = 4'b1111;
    run(0, 3, 1, 20, 4'b0000);
    chk("rr0_issue", 32'(issue_cyc), 1);
    chk("rr0_grant", 32'(iss_grant), 32'b0001);
    chk("rr0_done", 32'(done_vec), 32'b0001);
    chk("rr0_done_cyc", 32'(done_cyc), 4);
    for (int r = 1; r <= N; r++) begin
      run(r % N, 4, 1, 20, (r == N) ? 4'b1111 : 4'b0000);
      chk("rr_issue_gap", 32'(issue_cyc), 2);
      chk("rr_grant", 32'(iss_grant), 32'(1 << (r % N)));
      chk("rr_done", 32'(done_vec), 32'(1 << (r % N)));
      chk("rr_nrsp", 32'(nrsp), 1);
    end
    tick();
    chk("rr_idle", 32'(busy), 0);

    // Single job from requester 0, len=3, results 10 cycles after ISSUE.
    req_len[0 +: 6] = 6'd3;
    req_mode[0 +: 4] = 4'd0;
    req_valid = 4'b0001;
    run(0, 11, 4, 40, 4'b0001);
    chk("s_issue", 32'(issue_cyc), 1);
    chk("s_grant", 32'(iss_grant), 32'b0001);
    chk("s_cfg_len", 32'(iss_len), 3);
    chk("s_nfeed", 32'(nfeed), 4);
    chk("s_nrsp", 32'(nrsp), 4);
    chk("s_last_rsp", 32'(last_rsp), 15);
    chk("s_done_cyc", 32'(done_cyc), 15);
    chk("s_done_vec", 32'(done_vec), 32'b0001);
    chk("s_err", 32'(err_cyc), 0);
    tick();
    chk("s_idle", 32'(busy), 0);
    chk("s_cfg_hold", 32'(sfu_cfg_len), 3);

    // Watchdog: requester 2, len=1, only one beat ever returns.
    req_len[12 +: 6] = 6'd1;
    req_valid = 4'b0100;
    run(2, 5, 1, 300, 4'b0100);
    chk("wd_grant", 32'(iss_grant), 32'b0100);
    chk("wd_nrsp", 32'(nrsp), 1);
    chk("wd_err_gap", 32'(err_cyc - last_rsp), 255);
    chk("wd_err_vec", 32'(err_vec), 32'b0100);
    chk("wd_no_done", 32'(done_cyc), 0);
    tick();
    chk("wd_idle", 32'(busy), 0);

    // Early beats during FEED: requester 3, len=2, mode=1.
    req_len[18 +: 6] = 6'd2;
    req_mode[12 +: 4] = 4'd1;
    req_valid = 4'b1000;
    run(3, 2, 3, 30, 4'b1000);
    chk("eb_mode", 32'(iss_mode), 1);
    chk("eb_len", 32'(iss_len), 2);
    chk("eb_nfeed", 32'(nfeed), 3);
    chk("eb_nrsp", 32'(nrsp), 3);
    chk("eb_last_rsp", 32'(last_rsp), 5);
    chk("eb_done_cyc", 32'(done_cyc), 6);
    chk("eb_done_vec", 32'(done_vec), 32'b1000);
    tick();

    // Stray beats while IDLE are dropped and do not pre-load the next job's count.
    sfu_valid_out = 1'b1;
    sfu_data_out = 32'hBAD0_0000;
    tick();
    chk("stray_rsp1", 32'(rsp_valid), 0);
    tick();
    chk("stray_rsp2", 32'(rsp_valid), 0);
    chk("stray_busy", 32'(busy), 0);
    sfu_valid_out = 1'b0;
    req_len[6 +: 6] = 6'd1;
    req_valid = 4'b0010;
    run(1, 4, 2, 30, 4'b0000);
    chk("stray_grant", 32'(iss_grant), 32'b0010);
    chk("stray_nrsp", 32'(nrsp), 2);
    chk("stray_done_cyc", 32'(done_cyc), 6);
    tick();

    // Reset in the second FEED cycle of a job from requester 1 (rr_ptr is 2 here).
    req_len[6 +: 6] = 6'd3;
    tick();
    chk("rst_job_grant", 32'(req_grant), 32'b0010);
    tick();
    tick();
    chk("rst_job_feed", 32'(req_feed), 1);
    rst = 1'b1;
    tick();
    chk_idle_zero("rst_mid");
    rst = 1'b0;
    req_len = '0;
    req_valid = 4'b1111;
    run(0, 3, 1, 20, 4'b1111);
    chk("rst_rr_issue", 32'(issue_cyc), 1);
    chk("rst_rr_grant", 32'(iss_grant), 32'b0001);
    chk("rst_rr_done", 32'(done_cyc), 4);
    tick();
    chk("final_idle", 32'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sfu_arbiter.md
Name: sfu_arbiter

Overview:
- Shared-SFU scheduler: arbitrates NUM_REQ requesters (lanes/cores) for the single sfu instance and sequences one job at a time.
- Each job has four phases: select the requester, pulse sfu_req with the latched cfg, stream len+1 input words, then collect len+1 result beats and route them back to the owner.
- A drain watchdog keeps a hung job from holding the SFU forever.
- Sits between the CU requester ports and the sfu datapath.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
TIMEOUT, 255, max idle cycles between result beats in DRAIN before abort (8-bit counter)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
req_valid  in  NUM_REQ  job request per requester; level, held until rsp_done/rsp_err
req_len  in  6*NUM_REQ  per-requester length, actual-1 (slice i = [6i+5:6i])
req_mode  in  4*NUM_REQ  per-requester sfu mode (slice i = [4i+3:4i])
req_data  in  32*NUM_REQ  per-requester input word (slice i = [32i+31:32i])
req_grant  out  NUM_REQ  one-hot owner, high ISSUE..DONE
req_feed  out  1  granted requester's word is consumed this cycle; requester advances next cycle
rsp_valid  out  NUM_REQ  one-hot result strobe to owner
rsp_data  out  32  result word
rsp_done  out  NUM_REQ  1-cycle pulse, job completed normally
rsp_err  out  NUM_REQ  1-cycle pulse, job aborted by watchdog
sfu_req  out  1  1-cycle start pulse to sfu
sfu_cfg_len  out  6  latched length to sfu
sfu_cfg_mode  out  4  latched mode to sfu
sfu_data_in  out  32  input word to sfu
sfu_data_out  in  32  sfu result
sfu_valid_out  in  1  sfu result strobe
busy  out  1  state != IDLE

Behaviour:
- Reset values: all outputs 0; state IDLE; rr pointer 0; all counters 0. Reset asserted mid-job aborts immediately; no done/err pulse is issued.
- States: IDLE, ISSUE, FEED, DRAIN, DONE.
- IDLE:
  - If |req_valid, pick the first set bit scanning from rr_ptr upward, modulo NUM_REQ.
  - Latch owner idx, req_len[idx], req_mode[idx]; go to ISSUE next cycle.
  - Arbitration latency: 1 cycle from req_valid to grant.
- ISSUE:
  - sfu_req=1 for exactly 1 cycle; req_grant[idx]=1.
  - sfu_cfg_len/mode are driven from the latched values and stay stable from ISSUE through DONE. They are held at their last value in IDLE.
  - Go to FEED.
- FEED:
  - req_feed=1 every cycle.
  - sfu_data_in = req_data[idx], combinational mux; 0 in all other states.
  - feed_cnt counts 0..len. When feed_cnt==len, go to DRAIN and clear feed_cnt. Exactly len+1 words are fed.
- DRAIN:
  - Each sfu_valid_out beat registers sfu_data_out into rsp_data and asserts rsp_valid[idx] the next cycle (1-cycle latency).
  - out_cnt increments per beat. When out_cnt reaches len+1, go to DONE.
  - sfu_valid_out beats arriving in FEED are accepted identically (counted and forwarded); instr modes can return early.
  - Beats in IDLE/ISSUE/DONE are dropped.
  - Watchdog (8-bit) runs only in DRAIN and clears on each beat. When it reaches TIMEOUT: set err flag, go to DONE.
- DONE:
  - Pulse rsp_done[idx], or rsp_err[idx] if the err flag is set, for 1 cycle.
  - Set rr_ptr = idx+1 mod NUM_REQ; clear counters and the flag; return to IDLE.
  - A back-to-back request is granted no earlier than 2 cycles after DONE (IDLE, then ISSUE).
- Owner req_valid deassertion mid-job is ignored; the job runs to completion. Other requesters' req_valid changes are ignored while busy.
- len=0 is legal: 1 word fed, 1 beat expected.
- The last rsp_valid beat is registered and may coincide with the DONE cycle; rsp_done is never earlier than the last rsp_valid.
- Fairness: with all requesters asserting continuously, each is granted once per NUM_REQ jobs.

Test Plan:
- Single job: req_valid=0001, len=3, mode=0; sfu model returns 4 beats 10 cycles after ISSUE.
  - Expect sfu_req pulse the cycle after request, req_feed high for 4 cycles with sfu_data_in = req0 words.
  - Expect rsp_valid[0] ×4 with matching data, rsp_done[0] once, busy low afterwards.
- Round-robin: req_valid=1111 held continuously, len=0.
  - Expect grant order 0,1,2,3,0 and each rsp_done in that order.
- Watchdog: len=1, model returns only 1 beat.
  - Expect rsp_err[idx] pulse exactly 255 cycles after that beat, no rsp_done, then return to IDLE.
- Early beats: mode=3'b001, len=2, model returns beats during FEED.
  - Expect all 3 beats forwarded and rsp_done after the third.
- Reset mid-FEED: assert rst in FEED cycle 2.
  - Expect all outputs 0 the next cycle, state IDLE, rr_ptr 0, no done/err pulse.
- Stray beats: sfu_valid_out pulsed while IDLE.
  - Expect no rsp_valid and the next job's out_cnt starting from 0.
